chip_idle_lp_ctrl: RTL and testbench

- Consumes the combinational chip-level idle indication (all CPUs in WFI/WFE or held in reset, all banks idle or held in reset).
- Qualifies that indication with a programmable idle-timeout counter.
- Runs a four-phase request/acknowledge handshake with the PMU to enter and leave a clock-gated low-power state.
- Drives the chip clock-gate enable and exports state/statistics for CSR readback.

---
 rtl/chip_idle_pkg.sv | 17 +
 rtl/chip_idle_timer.sv | 34 +++
 rtl/chip_idle_lp_ctrl.sv | 125 ++++++++++++
 tb/tb_chip_idle_lp_ctrl.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/chip_idle_pkg.sv
// Shared definitions for the chip idle low-power controller.
//   lp_state_t : encoding of the low-power handshake FSM, exported on lp_state.
//   CNT_W_DEF  : default width of the idle-timeout counter and threshold.
//   STAT_W_DEF : default width of the saturating sleep-entry counter.
package chip_idle_pkg;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        REQ   = 2'd1,
        SLEEP = 2'd2,
        EXIT  = 2'd3
    } lp_state_t;

    localparam int CNT_W_DEF  = 16;
    localparam int STAT_W_DEF = 16;

endpackage

// File: rtl/chip_idle_timer.sv
// Saturating idle-timeout counter with a threshold compare.
//   clk, rst : core clock, asynchronous active-high reset
//   clr      : clear the count to 0 (wins over inc)
//   inc      : increment the count, holding at all-ones
//   thresh   : live threshold
//   ge       : count >= thresh
module chip_idle_timer #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    input  logic [CNT_W-1:0] thresh,
    output logic             ge
);

    logic [CNT_W-1:0] cnt_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_reg <= '0;
        end else if (clr) begin
            cnt_reg <= '0;
        end else if (inc && (cnt_reg != {CNT_W{1'b1}})) begin
            cnt_reg <= cnt_reg + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    // Compare against the current count so a lowered threshold takes
    // effect on the very next qualified cycle.
    assign ge = (cnt_reg >= thresh);

endmodule

// File: rtl/chip_idle_lp_ctrl.sv
// Chip-level idle low-power controller.
// Registers the chip idle indication, qualifies it with a programmable
// idle timeout, and runs a four-phase req/ack handshake with the PMU to
// enter and leave a clock-gated sleep state.
//   clk, rst         : core clock, asynchronous active-high reset
//   chip_is_idle     : combinational chip idle indication
//   cfg_en           : low-power entry enable
//   cfg_idle_thresh  : idle cycles required before requesting
//   wake_evt         : wake level/pulse
//   lp_ack           : PMU acknowledge
//   lp_req           : low-power request to PMU (registered)
//   clk_gate_en      : gate chip clocks (registered, SLEEP only)
//   lp_state         : current FSM state
//   sleep_cnt        : saturating count of SLEEP entries
module chip_idle_lp_ctrl
    import chip_idle_pkg::*;
#(
    parameter int CNT_W  = CNT_W_DEF,
    parameter int STAT_W = STAT_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              chip_is_idle,
    input  logic              cfg_en,
    input  logic [CNT_W-1:0]  cfg_idle_thresh,
    input  logic              wake_evt,
    input  logic              lp_ack,
    output logic              lp_req,
    output logic              clk_gate_en,
    output logic [1:0]        lp_state,
    output logic [STAT_W-1:0] sleep_cnt
);

    lp_state_t         state_reg, state_next;
    logic              idle_q_reg;
    logic              lp_req_reg, lp_req_next;
    logic              gate_reg, gate_next;
    logic [STAT_W-1:0] sleep_cnt_reg;
    logic              sleep_entry;
    logic              qual;
    logic              timer_clr, timer_inc, timer_ge;

    // cfg_en dropping or any wake behaves exactly like the chip going busy.
    assign qual = idle_q_reg & cfg_en & ~wake_evt;

    // Counting happens only in RUN; every other state (and any unqualified
    // cycle) holds the counter at 0 so a full threshold is needed after exit.
    assign timer_inc = (state_reg == RUN) & qual;
    assign timer_clr = (state_reg != RUN) | ~qual;

    chip_idle_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .clk    (clk),
        .rst    (rst),
        .clr    (timer_clr),
        .inc    (timer_inc),
        .thresh (cfg_idle_thresh),
        .ge     (timer_ge)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= RUN;
            idle_q_reg    <= 1'b0;
            lp_req_reg    <= 1'b0;
            gate_reg      <= 1'b0;
            sleep_cnt_reg <= '0;
        end else begin
            state_reg  <= state_next;
            idle_q_reg <= chip_is_idle;
            lp_req_reg <= lp_req_next;
            gate_reg   <= gate_next;
            if (sleep_entry && (sleep_cnt_reg != {STAT_W{1'b1}})) begin
                sleep_cnt_reg <= sleep_cnt_reg + {{(STAT_W-1){1'b0}}, 1'b1};
            end
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            RUN: begin
                // Holding off while lp_ack is still high keeps lp_req from
                // rising into a stale acknowledge.
                if (qual && timer_ge && !lp_ack) begin
                    state_next = REQ;
                end
            end
            REQ: begin
                // Abort has priority over a simultaneous acknowledge.
                if (!qual) begin
                    state_next = EXIT;
                end else if (lp_ack) begin
                    state_next = SLEEP;
                end
            end
            SLEEP: begin
                // lp_ack is deliberately ignored here.
                if (!qual) begin
                    state_next = EXIT;
                end
            end
            EXIT: begin
                if (!lp_ack) begin
                    state_next = RUN;
                end
            end
            default: begin
                state_next = RUN;
            end
        endcase
    end

    // Outputs are registered copies of the next state's decode.
    assign lp_req_next = (state_next == REQ) || (state_next == SLEEP);
    assign gate_next   = (state_next == SLEEP);
    assign sleep_entry = (state_reg == REQ) && (state_next == SLEEP);

    assign lp_req      = lp_req_reg;
    assign clk_gate_en = gate_reg;
    assign lp_state    = state_reg;
    assign sleep_cnt   = sleep_cnt_reg;

endmodule

// File: tb/tb_chip_idle_lp_ctrl.sv
module tb_chip_idle_lp_ctrl;
    import chip_idle_pkg::*;

    localparam int CNT_W  = 8;
    localparam int STAT_W = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic              chip_is_idle;
    logic              cfg_en;
    logic [CNT_W-1:0]  cfg_idle_thresh;
    logic              wake_evt;
    logic              lp_ack;
    logic              lp_req;
    logic              clk_gate_en;
    logic [1:0]        lp_state;
    logic [STAT_W-1:0] sleep_cnt;

    chip_idle_lp_ctrl #(
        .CNT_W  (CNT_W),
        .STAT_W (STAT_W)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .chip_is_idle    (chip_is_idle),
        .cfg_en          (cfg_en),
        .cfg_idle_thresh (cfg_idle_thresh),
        .wake_evt        (wake_evt),
        .lp_ack          (lp_ack),
        .lp_req          (lp_req),
        .clk_gate_en     (clk_gate_en),
        .lp_state        (lp_state),
        .sleep_cnt       (sleep_cnt)
    );

    always #5 clk = ~clk;

    // Posedge count; an expectation tagged with cycle c is checked at the
    // negedge following posedge number c.
    int cyc = 0;
    always @(posedge clk) cyc = cyc + 1;

    typedef struct {
        int         c;
        logic       req;
        logic       gate;
        logic [1:0] st;
        logic [1:0] cnt;
        string      tag;
    } exp_t;

    exp_t q[$];
    int   errors = 0;
    int   checks = 0;
    event chk_ev;

    task automatic ex(input int c, input logic r, input logic g,
                      input logic [1:0] s, input logic [1:0] n, input string t);
        exp_t e;
        e.c = c; e.req = r; e.gate = g; e.st = s; e.cnt = n; e.tag = t;
        q.push_back(e);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Monitor: compares every due expectation at the negedge, or at once
    // when the stimulus signals an asynchronous event.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk or chk_ev);
            while (q.size() > 0 && q[0].c <= cyc) begin
                e = q.pop_front();
                checks++;
                if (lp_req !== e.req || clk_gate_en !== e.gate ||
                    lp_state !== e.st || sleep_cnt !== e.cnt) begin
                    errors++;
                    $display("FAIL %s cyc=%0d got req=%b gate=%b st=%0d cnt=%0d want req=%b gate=%b st=%0d cnt=%0d",
                             e.tag, cyc, lp_req, clk_gate_en, lp_state, sleep_cnt,
                             e.req, e.gate, e.st, e.cnt);
                end else begin
                    $display("ok   %s cyc=%0d req=%b gate=%b st=%0d cnt=%0d",
                             e.tag, cyc, lp_req, clk_gate_en, lp_state, sleep_cnt);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog cyc=%0d pending=%0d required=0", cyc, q.size());
        $fatal(1, "watchdog expired");
    end

    initial begin
        int b;
        logic [1:0] pc;

        rst = 1'b1; chip_is_idle = 1'b0; cfg_en = 1'b0; cfg_idle_thresh = '0;
        wake_evt = 1'b0; lp_ack = 1'b0;
        ex(1, 0, 0, RUN, 0, "reset_hold");
        tick(2);
        rst = 1'b0;
        ex(cyc, 0, 0, RUN, 0, "reset_release");

        // Basic entry, thresh = 4: lp_req 6 cycles after the idle edge.
        cfg_en = 1'b1; cfg_idle_thresh = 8'd4;
        b = cyc; chip_is_idle = 1'b1;
        ex(b + 1, 0, 0, RUN, 0, "basic_count");
        ex(b + 5, 0, 0, RUN, 0, "basic_pre_req");
        ex(b + 6, 1, 0, REQ, 0, "basic_req");
        tick(8);
        lp_ack = 1'b1;
        ex(b + 8, 1, 0, REQ, 0, "basic_wait_ack");
        ex(b + 9, 1, 1, SLEEP, 1, "basic_sleep");
        tick(1);
        lp_ack = 1'b0;  // early ack drop must be ignored in SLEEP
        ex(b + 11, 1, 1, SLEEP, 1, "early_ack_drop");
        tick(3);

        // Wake from SLEEP by chip going busy: outputs fall 2 cycles later.
        b = cyc; chip_is_idle = 1'b0;
        ex(b + 1, 1, 1, SLEEP, 1, "wakeA_hold");
        ex(b + 2, 0, 0, EXIT, 1, "wakeA_exit");
        ex(b + 3, 0, 0, RUN, 1, "wakeA_run");
        tick(4);

        // Glitch filtering, thresh = 10.
        cfg_idle_thresh = 8'd10;
        b = cyc; chip_is_idle = 1'b1;
        ex(b + 8, 0, 0, RUN, 1, "glitch_first_run");
        tick(8);
        chip_is_idle = 1'b0;
        tick(1);
        b = cyc; chip_is_idle = 1'b1;
        ex(b + 11, 0, 0, RUN, 1, "glitch_pre_req");
        ex(b + 12, 1, 0, REQ, 1, "glitch_req");
        tick(12);

        // Abort from REQ by a one-cycle wake pulse; then fresh threshold.
        b = cyc; wake_evt = 1'b1;
        ex(b + 1, 0, 0, EXIT, 1, "abort_exit");
        tick(1);
        wake_evt = 1'b0;
        ex(b + 2, 0, 0, RUN, 1, "abort_run");
        ex(b + 12, 0, 0, RUN, 1, "abort_recount");
        ex(b + 13, 1, 0, REQ, 1, "abort_rereq");
        tick(12);

        // Simultaneous ack and wake in REQ: abort wins, EXIT waits for ack low.
        b = cyc; lp_ack = 1'b1; wake_evt = 1'b1;
        ex(b + 1, 0, 0, EXIT, 1, "simul_exit");
        tick(1);
        wake_evt = 1'b0;
        ex(b + 2, 0, 0, EXIT, 1, "simul_hold1");
        ex(b + 3, 0, 0, EXIT, 1, "simul_hold2");
        tick(2);
        lp_ack = 1'b0; chip_is_idle = 1'b0;
        ex(b + 4, 0, 0, RUN, 1, "simul_run");
        tick(3);

        // Threshold 0 entries and sleep_cnt saturation at 2'b11.
        pc = 2'd1;
        cfg_idle_thresh = 8'd0;
        for (int i = 0; i < 4; i++) begin
            b = cyc; chip_is_idle = 1'b1;
            ex(b + 1, 0, 0, RUN, pc, "thr0_run");
            ex(b + 2, 1, 0, REQ, pc, "thr0_req");
            tick(2);
            lp_ack = 1'b1;
            if (pc != 2'd3) pc = pc + 2'd1;
            ex(b + 3, 1, 1, SLEEP, pc, "sat_sleep");
            tick(1);
            chip_is_idle = 1'b0; lp_ack = 1'b0;
            ex(b + 4, 1, 1, SLEEP, pc, "sat_hold");
            ex(b + 5, 0, 0, EXIT, pc, "sat_exit");
            ex(b + 6, 0, 0, RUN, pc, "sat_run");
            tick(3);
        end

        // All-ones threshold: counter must saturate, not wrap.
        cfg_idle_thresh = 8'hFF;
        b = cyc; chip_is_idle = 1'b1;
        ex(b + 256, 0, 0, RUN, 3, "cnt_sat_pre");
        ex(b + 257, 1, 0, REQ, 3, "cnt_sat_req");
        tick(257);
        lp_ack = 1'b1;
        ex(b + 258, 1, 1, SLEEP, 3, "cnt_sat_sleep");
        tick(3);

        // Asynchronous reset mid-SLEEP, checked away from any clock edge.
        #1;
        rst = 1'b1;
        #1;
        ex(cyc, 0, 0, RUN, 0, "async_rst");
        -> chk_ev;
        lp_ack = 1'b0;
        tick(2);
        rst = 1'b0;
        ex(cyc, 0, 0, RUN, 0, "post_rst");
        tick(3);

        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL queue_drain pending=%0d required=0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
